// File: rtl/seq_detector_param_pkg.sv
// seqdet_pkg: shared constants, helpers and types for the parametrised
// serial sequence detector (seq_detector_param).
//   SEQDET_MAX_LEN  - longest pattern the detector is built for
//   seqdet_state_w  - width of the prefix-length state register
//   seqdet_mode_e   - overlap / non-overlap detection mode encoding
package seqdet_pkg;

    localparam int SEQDET_MAX_LEN = 16;

    // State k runs 0..len inclusive, so it needs room for len+1 values.
    function automatic int seqdet_state_w(input int len);
        return $clog2(len + 1);
    endfunction

    typedef enum logic {
        SEQDET_NONOVERLAP = 1'b0,
        SEQDET_OVERLAP    = 1'b1
    } seqdet_mode_e;

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial-data side bundle of the sequence detector.
//   din_valid, din   - qualified serial data bit
//   overlap_en       - 1 = overlapping detection, 0 = non-overlapping
//   clear            - synchronous clear of state and counter
//   detected         - Moore match flag
//   match_count      - saturating match count (only with SEQDET_COUNT_EN)
// Modports: master drives the serial data/controls, slave is the detector.
// Optional feature macro: SEQDET_COUNT_EN.
interface seq_detector_param_if #(
    parameter int CNT_W = 8
) ();
    logic din_valid;
    logic din;
    logic overlap_en;
    logic clear;
    logic detected;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("seq_detector_param_if: CNT_W must be at least 1");
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] match_count;

    modport master (output din_valid, output din, output overlap_en,
                    output clear, input detected, input match_count);
    modport slave  (input din_valid, input din, input overlap_en,
                    input clear, output detected, output match_count);
`else
    modport master (output din_valid, output din, output overlap_en,
                    output clear, input detected);
    modport slave  (input din_valid, input din, input overlap_en,
                    input clear, output detected);
`endif

endinterface

// File: rtl/seq_detector_param_prefix_next.sv
// seqdet_prefix_next: combinational next-state function of the detector.
// Given the currently matched prefix length k and the incoming bit, returns
// the longest pattern prefix that is a suffix of (prefix k, din).
//   k      - current matched prefix length, 0..PAT_LEN
//   din    - incoming serial bit
//   mode   - overlap / non-overlap; only matters when k == PAT_LEN
//   k_next - next matched prefix length
module seqdet_prefix_next
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10101,
    parameter int                 SW      = seqdet_state_w(PAT_LEN)
) (
    input  logic [SW-1:0] k,
    input  logic          din,
    input  seqdet_mode_e  mode,
    output logic [SW-1:0] k_next
);

    localparam logic [SW-1:0] K_FULL = SW'(PAT_LEN);

    // Bit p of PATTERN, 0 when p falls outside the pattern.
    function automatic logic pbit(input int p);
        logic [PAT_LEN-1:0] t;
        if (p < 0 || p >= PAT_LEN) return 1'b0;
        t = PATTERN >> p;
        return t[0];
    endfunction

    always_comb begin
        int   kk;
        logic ok;
        // A completed match in non-overlap mode keeps no history.
        kk = (k == K_FULL && mode == SEQDET_NONOVERLAP) ? 0 : int'(k);
        k_next = '0;
        // Prefix position q sits at PATTERN[PAT_LEN-1-q]. Candidate j matches
        // when prefix positions kk-j+1..kk-1 equal positions 0..j-2 and din
        // equals position j-1. Ascending j leaves the longest match.
        for (int j = 1; j <= PAT_LEN; j++) begin
            ok = (j <= kk + 1) && (din == pbit(PAT_LEN - j));
            for (int i = 0; i < PAT_LEN - 1; i++) begin
                if (i < j - 1 && pbit(PAT_LEN - 2 - kk + j - i) != pbit(PAT_LEN - 1 - i))
                    ok = 1'b0;
            end
            if (ok) k_next = SW'(j);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Moore serial bit-pattern detector.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - seq_detector_param_if.slave (din_valid, din, overlap_en, clear,
//            detected, and match_count when SEQDET_COUNT_EN is defined)
// PATTERN[PAT_LEN-1] is the first bit of the pattern on the wire.
// Optional feature macro: SEQDET_COUNT_EN adds a CNT_W-bit saturating
// match counter on bus.match_count.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10101,
    parameter int                 CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_detector_param_if.slave bus
);

    localparam int              SW     = seqdet_state_w(PAT_LEN);
    localparam logic [SW-1:0]   K_FULL = SW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > SEQDET_MAX_LEN) begin : g_len_chk
        $error("seq_detector_param: PAT_LEN out of range 2..16");
    end
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    logic [SW-1:0] state_p0;
    logic [SW-1:0] k_next;
    logic          det_p0;
    logic          hit;
    seqdet_mode_e  mode;

    assign mode = seqdet_mode_e'(bus.overlap_en);

    seqdet_prefix_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_prefix_next (
        .k      (state_p0),
        .din    (bus.din),
        .mode   (mode),
        .k_next (k_next)
    );

    // A valid edge landing on the full pattern.
    assign hit = bus.din_valid && (k_next == K_FULL);

    // ---- stage p0: state register; detected is a flop tracking k == PAT_LEN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= '0;
            det_p0   <= 1'b0;
        end else if (bus.clear) begin
            state_p0 <= '0;
            det_p0   <= 1'b0;
        end else if (bus.din_valid) begin
            state_p0 <= k_next;
            det_p0   <= (k_next == K_FULL);
        end
    end

    assign bus.detected = det_p0;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if (bus.clear) begin
            cnt_p0 <= '0;
        end else if (hit) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign bus.match_count = cnt_p0;
`else
    logic unused_hit;
    assign unused_hit = hit;
`endif

endmodule
